chia16_seq: RTL and testbench

CHIA16_SEQ -- requirements
Module: chia16_seq

---
 rtl/chia16_seq.sv | 125 ++++++++++++
 tb/tb_chia16_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/chia16_seq.sv
// Sequential 16-by-8 unsigned restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero skips the calculation and reports q=FFFF, r=a[7:0], dz=1.
module chia16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    input  logic        start,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [8:0]  prem_q, prem_d;
    logic [15:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] q_q, q_d;
    logic [7:0]  r_q, r_d;
    logic        dz_q, dz_d;

    logic [9:0]  shifted;
    logic [8:0]  diff;
    logic        ge;

    // The partial remainder is always below the divisor, so the shifted value's
    // top bit stays clear and a 9-bit difference is exact whenever ge is set.
    always_comb begin
        shifted = {prem_q, dvd_q[15]};
        ge      = (shifted >= {2'b00, dvs_q});
        diff    = shifted[8:0] - {1'b0, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b != 8'd0) begin
                        dvd_d   = a;
                        dvs_d   = b;
                        prem_d  = 9'd0;
                        quo_d   = 16'd0;
                        cnt_d   = 4'd0;
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end else begin
                        q_d     = 16'hFFFF;
                        r_d     = a[7:0];
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                prem_d = ge ? diff : shifted[8:0];
                quo_d  = {quo_q[14:0], ge};
                dvd_d  = {dvd_q[14:0], 1'b0};
                cnt_d  = cnt_q + 4'd1;
                // Results are published only on the last step; q/r stay put during CALC.
                if (cnt_q == 4'd15) begin
                    q_d     = {quo_q[14:0], ge};
                    r_d     = prem_d[7:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= 16'd0;
            dvs_q   <= 8'd0;
            prem_q  <= 9'd0;
            quo_q   <= 16'd0;
            cnt_q   <= 4'd0;
            q_q     <= 16'd0;
            r_q     <= 8'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_chia16_seq.sv
// Directed bench for chia16_seq: hand-computed quotient/remainder vectors plus
// latency, ignored-start, reset-abort and back-to-back scenarios.
module tb_chia16_seq;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  b;
    logic        start;
    logic [15:0] q;
    logic [7:0]  r;
    logic        busy;
    logic        done;
    logic        dz;

    int errors = 0;
    int checks = 0;

    chia16_seq dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; n = cycles spent after the call, bc = busy cycles seen.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_div(input logic [15:0] av, input logic [7:0] bv,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz);
        logic [15:0] q0;
        logic [7:0]  r0;
        int n;
        int bc;
        int moved;
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1;
        q0 = q; r0 = r;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; bc = 0; moved = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            if (q !== q0 || r !== r0) moved = 1;
            @(posedge clk); #1;
            n++;
        end
        chk("latency",     n,    edz ? 32'd0 : 32'd16);
        chk("busy_cycles", bc,   edz ? 32'd0 : 32'd16);
        chk("qr_hold",     moved, 32'd0);
        chk("done",        done, 32'd1);
        chk("q",           q,    eq);
        chk("r",           r,    er);
        chk("dz",          dz,   edz);
        $display("div a=%0d b=%0d -> q=%0d r=%0d dz=%0b (exp q=%0d r=%0d dz=%0b)",
                 av, bv, q, r, dz, eq, er, edz);
        @(posedge clk); #1;
        chk("done_width", done, 32'd0);
        chk("q_hold",     q,    eq);
    endtask

    int n;
    int bc;
    int saw_done;
    logic [15:0] ra;
    logic [7:0]  rb;

    initial begin
        rst = 1'b1; a = 16'd0; b = 8'd0; start = 1'b0;
        #12;
        chk("rst_q",    q,    32'd0);
        chk("rst_r",    r,    32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_dz",   dz,   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_div(16'd1000,  8'd7,   16'd142,   8'd6,  1'b0);
        do_div(16'd65535, 8'd255, 16'd257,   8'd0,  1'b0);
        do_div(16'd5,     8'd9,   16'd0,     8'd5,  1'b0);
        do_div(16'd0,     8'd1,   16'd0,     8'd0,  1'b0);
        do_div(16'h1234,  8'd0,   16'hFFFF,  8'h34, 1'b1);
        do_div(16'd12345, 8'd123, 16'd100,   8'd45, 1'b0);
        do_div(16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0);
        do_div(16'd255,   8'd16,  16'd15,    8'd15, 1'b0);
        do_div(16'd40000, 8'd200, 16'd200,   8'd0,  1'b0);

        // Second start during CALC must be ignored and not queued.
        @(posedge clk); #1;
        a = 16'd1000; b = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("ign_busy", busy, 32'd1);
        a = 16'd9; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, bc);
        chk("ign_q", q, 32'd142);
        chk("ign_r", r, 32'd6);
        $display("ignored-start: q=%0d r=%0d", q, r);
        repeat (3) begin @(posedge clk); #1; end
        chk("ign_not_queued", busy, 32'd0);

        // Reset in the 8th CALC cycle aborts immediately, with no done pulse afterwards.
        a = 16'd1000; b = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 32'd0);
        chk("abort_q",    q,    32'd0);
        chk("abort_r",    r,    32'd0);
        chk("abort_done", done, 32'd0);
        chk("abort_dz",   dz,   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 0;
        repeat (20) begin
            if (done || busy) saw_done = 1;
            @(posedge clk); #1;
        end
        chk("abort_no_done", saw_done, 32'd0);
        $display("reset-abort: q=%0d r=%0d busy=%0b", q, r, busy);
        do_div(16'd200, 8'd10, 16'd20, 8'd0, 1'b0);

        // start held high: back-to-back divisions with one IDLE cycle between them.
        @(posedge clk); #1;
        a = 16'd100; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        wait_done(n, bc);
        chk("b2b_q",   q, 32'd33);
        chk("b2b_r",   r, 32'd1);
        chk("b2b_lat", n, 32'd16);
        a = 16'd77; b = 8'd10;
        @(posedge clk); #1;
        chk("b2b_idle_busy", busy, 32'd0);
        chk("b2b_idle_done", done, 32'd0);
        @(posedge clk); #1;
        chk("b2b_restart", busy, 32'd1);
        start = 1'b0;
        wait_done(n, bc);
        chk("b2b_q2", q, 32'd7);
        chk("b2b_r2", r, 32'd7);
        $display("back-to-back: q=%0d r=%0d", q, r);

        // Modest random sweep against native arithmetic.
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            do_div(ra, rb, ra / {8'd0, rb}, 8'(ra % {8'd0, rb}), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
